vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 sync generator.
- Produces hsync/vsync/video_on, pixel addresses and line/frame strobes for any resolution.
- Sync polarity is selectable, and the sync/video_on outputs carry a programmable delay so they align with a downstream pixel-fetch pipeline.
- Sits between the pixel clock domain root and the framebuffer reader / DAC interface.

---
 rtl/vga_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync / pixel-address generator.
//
// Purpose: produces hsync/vsync/video_on, visible pixel addresses and
// line/frame strobes for an arbitrary display mode. The sync and video_on
// outputs are delayed by OUT_DLY cycles so they line up with a downstream
// pixel-fetch pipeline that consumes the undelayed addresses.
//
// Ports:
//   vga_clk       in   pixel clock
//   rst           in   synchronous active-high reset
//   vga_hsync     out  horizontal sync, active level HS_POL, delayed OUT_DLY
//   vga_vsync     out  vertical sync, active level VS_POL, delayed OUT_DLY
//   vga_video_on  out  visible-area flag, delayed OUT_DLY
//   vga_h_addr    out  visible pixel column (0 outside the visible area)
//   vga_v_addr    out  visible line (0 outside the visible area)
//   pix_req       out  undelayed visible flag qualifying the addresses
//   line_start    out  one-cycle pulse on the first pixel of every line
//   frame_start   out  one-cycle pulse on the first pixel of line 0
//
// Optional build macro VGA_TIMING_RUNTIME_EN adds cfg_* inputs and cfg_load.
// A cfg_load pulse captures a new mode into pending registers; the pending
// mode becomes active on the next frame wrap so a frame is never torn.
module vga_timing_gen #(
  parameter int CNT_W   = 12,
  parameter int H_VA    = 640,
  parameter int H_FP    = 16,
  parameter int H_SP    = 96,
  parameter int H_BP    = 48,
  parameter int V_VA    = 480,
  parameter int V_FP    = 10,
  parameter int V_SP    = 2,
  parameter int V_BP    = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int OUT_DLY = 1
) (
  input  logic             vga_clk,
  input  logic             rst,
`ifdef VGA_TIMING_RUNTIME_EN
  input  logic [CNT_W-1:0] cfg_h_va,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sp,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_va,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sp,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic             cfg_load,
`endif
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_video_on,
  output logic [CNT_W-1:0] vga_h_addr,
  output logic [CNT_W-1:0] vga_v_addr,
  output logic             pix_req,
  output logic             line_start,
  output logic             frame_start
);

  // Elaboration-time sanity checks on the parameter set.
  if (H_VA + H_FP + H_SP + H_BP >= (1 << CNT_W)) begin : g_ht_chk
    $error("vga_timing_gen: horizontal total does not fit in CNT_W");
  end
  if (V_VA + V_FP + V_SP + V_BP >= (1 << CNT_W)) begin : g_vt_chk
    $error("vga_timing_gen: vertical total does not fit in CNT_W");
  end
  if (OUT_DLY < 0 || OUT_DLY > 8) begin : g_dly_chk
    $error("vga_timing_gen: OUT_DLY must be in 0..8");
  end

  typedef struct packed {
    logic [CNT_W-1:0] h_va, h_fp, h_sp, h_bp;
    logic [CNT_W-1:0] v_va, v_fp, v_sp, v_bp;
  } timing_t;

  localparam timing_t PARAM_TIMING = '{
    h_va: CNT_W'(H_VA), h_fp: CNT_W'(H_FP), h_sp: CNT_W'(H_SP), h_bp: CNT_W'(H_BP),
    v_va: CNT_W'(V_VA), v_fp: CNT_W'(V_FP), v_sp: CNT_W'(V_SP), v_bp: CNT_W'(V_BP)
  };

  timing_t          tm;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] h_sp_beg, h_sp_end, h_last;
  logic [CNT_W-1:0] v_sp_beg, v_sp_end, v_last;
  logic             h_wrap, v_wrap, frame_wrap;
  logic             h_vis, v_vis, h_in_sp, v_in_sp;

  // Segment boundaries, in VA -> FP -> SP -> BP order.
  assign h_sp_beg = tm.h_va + tm.h_fp;
  assign h_sp_end = h_sp_beg + tm.h_sp;
  assign h_last   = h_sp_end + tm.h_bp - CNT_W'(1);
  assign v_sp_beg = tm.v_va + tm.v_fp;
  assign v_sp_end = v_sp_beg + tm.v_sp;
  assign v_last   = v_sp_end + tm.v_bp - CNT_W'(1);

  assign h_wrap     = (h_cnt_q == h_last);
  assign v_wrap     = (v_cnt_q == v_last);
  assign frame_wrap = h_wrap & v_wrap;

  assign h_vis   = (h_cnt_q < tm.h_va);
  assign v_vis   = (v_cnt_q < tm.v_va);
  assign h_in_sp = (h_cnt_q >= h_sp_beg) & (h_cnt_q < h_sp_end);
  assign v_in_sp = (v_cnt_q >= v_sp_beg) & (v_cnt_q < v_sp_end);

`ifdef VGA_TIMING_RUNTIME_EN
  timing_t act_q, pend_q;
  logic    pend_vld_q;

  assign tm = act_q;

  // A load on the wrap edge lands in pend_q after the old pending mode has
  // been applied, so it takes effect one frame later.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      act_q      <= PARAM_TIMING;
      pend_q     <= PARAM_TIMING;
      pend_vld_q <= 1'b0;
    end else begin
      if (frame_wrap && pend_vld_q) begin
        act_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end
      if (cfg_load) begin
        pend_q     <= '{h_va: cfg_h_va, h_fp: cfg_h_fp, h_sp: cfg_h_sp, h_bp: cfg_h_bp,
                        v_va: cfg_v_va, v_fp: cfg_v_fp, v_sp: cfg_v_sp, v_bp: cfg_v_bp};
        pend_vld_q <= 1'b1;
      end
    end
  end
`else
  assign tm = PARAM_TIMING;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  logic hs1_q, vs1_q;

  // Counters plus stage-1 outputs, all decoded from the previous counts.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      vga_h_addr  <= '0;
      vga_v_addr  <= '0;
      pix_req     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs1_q       <= ~HS_POL;
      vs1_q       <= ~VS_POL;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      vga_h_addr  <= h_vis ? h_cnt_q : '0;
      vga_v_addr  <= v_vis ? v_cnt_q : '0;
      pix_req     <= h_vis & v_vis;
      line_start  <= (h_cnt_q == '0);
      frame_start <= (h_cnt_q == '0) & (v_cnt_q == '0);
      hs1_q       <= h_in_sp ? HS_POL : ~HS_POL;
      vs1_q       <= v_in_sp ? VS_POL : ~VS_POL;
    end
  end

  // Extra alignment stages for sync and video_on; pix_req doubles as the
  // stage-1 video_on.
  if (OUT_DLY == 0) begin : g_nodly
    assign vga_hsync    = hs1_q;
    assign vga_vsync    = vs1_q;
    assign vga_video_on = pix_req;
  end else begin : g_dly
    logic [OUT_DLY-1:0] hs_dly_q, vs_dly_q, vo_dly_q;

    always_ff @(posedge vga_clk) begin
      if (rst) begin
        hs_dly_q <= {OUT_DLY{~HS_POL}};
        vs_dly_q <= {OUT_DLY{~VS_POL}};
        vo_dly_q <= '0;
      end else begin
        hs_dly_q[0] <= hs1_q;
        vs_dly_q[0] <= vs1_q;
        vo_dly_q[0] <= pix_req;
        for (int i = 1; i < OUT_DLY; i++) begin
          hs_dly_q[i] <= hs_dly_q[i-1];
          vs_dly_q[i] <= vs_dly_q[i-1];
          vo_dly_q[i] <= vo_dly_q[i-1];
        end
      end
    end

    assign vga_hsync    = hs_dly_q[OUT_DLY-1];
    assign vga_vsync    = vs_dly_q[OUT_DLY-1];
    assign vga_video_on = vo_dly_q[OUT_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 14x8 mode. Three instances share clock
// and reset: plain (OUT_DLY=0), delayed (OUT_DLY=3), active-high syncs.
// The reference model derives every output from the number of clock edges
// since reset release using plain modular arithmetic on frame position.
module tb_vga_timing_gen;

  localparam int HVA = 8, HFP = 2, HSP = 3, HBP = 1;
  localparam int VVA = 4, VFP = 1, VSP = 2, VBP = 1;
  localparam int HT = HVA + HFP + HSP + HBP;   // 14
  localparam int VT = VVA + VFP + VSP + VBP;   // 8
  localparam int FT = HT * VT;                 // 112

  typedef struct packed {
    logic hs, vs, vo, pix, ls, fs;
    logic [11:0] ha, va;
  } obs_t;

  logic vga_clk = 1'b0;
  logic rst = 1'b1;
  always #5 vga_clk = ~vga_clk;

  int n = 0;          // edges since reset released (0 = in reset)
  int tests = 0;
  int fails = 0;

  logic hs0, vs0, vo0, pix0, ls0, fs0; logic [11:0] ha0, va0;
  logic hs1, vs1, vo1, pix1, ls1, fs1; logic [11:0] ha1, va1;
  logic hs2, vs2, vo2, pix2, ls2, fs2; logic [11:0] ha2, va2;
  obs_t o0, o1, o2;
  assign o0 = {hs0, vs0, vo0, pix0, ls0, fs0, ha0, va0};
  assign o1 = {hs1, vs1, vo1, pix1, ls1, fs1, ha1, va1};
  assign o2 = {hs2, vs2, vo2, pix2, ls2, fs2, ha2, va2};

  vga_timing_gen #(.CNT_W(12), .H_VA(HVA), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
    .V_VA(VVA), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .OUT_DLY(0))
  dut0 (.vga_clk(vga_clk), .rst(rst),
`ifdef VGA_TIMING_RUNTIME_EN
    .cfg_h_va(12'd8), .cfg_h_fp(12'd2), .cfg_h_sp(12'd3), .cfg_h_bp(12'd1),
    .cfg_v_va(12'd4), .cfg_v_fp(12'd1), .cfg_v_sp(12'd2), .cfg_v_bp(12'd1), .cfg_load(1'b0),
`endif
    .vga_hsync(hs0), .vga_vsync(vs0), .vga_video_on(vo0), .vga_h_addr(ha0), .vga_v_addr(va0),
    .pix_req(pix0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(.CNT_W(12), .H_VA(HVA), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
    .V_VA(VVA), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .OUT_DLY(3))
  dut1 (.vga_clk(vga_clk), .rst(rst),
`ifdef VGA_TIMING_RUNTIME_EN
    .cfg_h_va(12'd8), .cfg_h_fp(12'd2), .cfg_h_sp(12'd3), .cfg_h_bp(12'd1),
    .cfg_v_va(12'd4), .cfg_v_fp(12'd1), .cfg_v_sp(12'd2), .cfg_v_bp(12'd1), .cfg_load(1'b0),
`endif
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_video_on(vo1), .vga_h_addr(ha1), .vga_v_addr(va1),
    .pix_req(pix1), .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(.CNT_W(12), .H_VA(HVA), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
    .V_VA(VVA), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP), .HS_POL(1'b1), .VS_POL(1'b1), .OUT_DLY(0))
  dut2 (.vga_clk(vga_clk), .rst(rst),
`ifdef VGA_TIMING_RUNTIME_EN
    .cfg_h_va(12'd8), .cfg_h_fp(12'd2), .cfg_h_sp(12'd3), .cfg_h_bp(12'd1),
    .cfg_v_va(12'd4), .cfg_v_fp(12'd1), .cfg_v_sp(12'd2), .cfg_v_bp(12'd1), .cfg_load(1'b0),
`endif
    .vga_hsync(hs2), .vga_vsync(vs2), .vga_video_on(vo2), .vga_h_addr(ha2), .vga_v_addr(va2),
    .pix_req(pix2), .line_start(ls2), .frame_start(fs2));

`ifdef VGA_TIMING_RUNTIME_EN
  logic [11:0] c_hva = 12'd8;
  logic cfg_load = 1'b0;
  logic hs3, vs3, vo3, pix3, ls3, fs3; logic [11:0] ha3, va3;
  vga_timing_gen #(.CNT_W(12), .H_VA(HVA), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
    .V_VA(VVA), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .OUT_DLY(0))
  dut3 (.vga_clk(vga_clk), .rst(rst),
    .cfg_h_va(c_hva), .cfg_h_fp(12'd2), .cfg_h_sp(12'd3), .cfg_h_bp(12'd1),
    .cfg_v_va(12'd4), .cfg_v_fp(12'd1), .cfg_v_sp(12'd2), .cfg_v_bp(12'd1), .cfg_load(cfg_load),
    .vga_hsync(hs3), .vga_vsync(vs3), .vga_video_on(vo3), .vga_h_addr(ha3), .vga_v_addr(va3),
    .pix_req(pix3), .line_start(ls3), .frame_start(fs3));
`endif

  // Expected outputs after nn edges since reset release. Undelayed outputs
  // describe frame position nn-1; delayed ones describe position nn-1-d and
  // stay at their reset values until that position exists.
  function automatic obs_t model(int nn, int d, bit hp, bit vp);
    obs_t e;
    int p, h, v;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (nn >= 1) begin
      p = (nn - 1) % FT; h = p % HT; v = p / HT;
      e.pix = (h < HVA) && (v < VVA);
      e.ha  = (h < HVA) ? 12'(h) : 12'd0;
      e.va  = (v < VVA) ? 12'(v) : 12'd0;
      e.ls  = (h == 0);
      e.fs  = (p == 0);
    end
    if (nn >= 1 + d) begin
      p = (nn - 1 - d) % FT; h = p % HT; v = p / HT;
      e.hs = (h >= HVA + HFP && h < HVA + HFP + HSP) ? hp : ~hp;
      e.vs = (v >= VVA + VFP && v < VVA + VFP + VSP) ? vp : ~vp;
      e.vo = (h < HVA) && (v < VVA);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    if (rst) n = 0; else n++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++; if (o0 !== model(0, 0, 0, 0)) begin fails++; $display("FAIL reset_d0 got %h exp %h", o0, model(0, 0, 0, 0)); end
    tests++; if (o1 !== model(0, 3, 0, 0)) begin fails++; $display("FAIL reset_d1 got %h exp %h", o1, model(0, 3, 0, 0)); end
    tests++; if ({hs2, vs2} !== 2'b00) begin fails++; $display("FAIL reset_pol got %b exp 00", {hs2, vs2}); end
  endtask

  task automatic test_small_timing();
    int hs_lo = 0, vs_lo = 0, vo_hi = 0, ls_n = 0, fs_n = 0;
    rst = 1'b0;
    tick();
    tests++; if (ls0 !== 1'b1 || fs0 !== 1'b1) begin fails++; $display("FAIL first_strobes got ls=%b fs=%b exp 1 1", ls0, fs0); end
    for (int k = 0; k < 2 * FT + 5; k++) begin
      if (k > 0) tick();
      tests++; if (o0 !== model(n, 0, 0, 0)) begin fails++; $display("FAIL small n=%0d got %h exp %h", n, o0, model(n, 0, 0, 0)); end
      if (n >= 1 && n <= FT) begin
        hs_lo += (hs0 == 1'b0); vs_lo += (vs0 == 1'b0); vo_hi += vo0;
        ls_n += ls0; fs_n += fs0;
      end
    end
    tests++; if (hs_lo !== 3 * VT) begin fails++; $display("FAIL hs_low_cycles got %0d exp %0d", hs_lo, 3 * VT); end
    tests++; if (vs_lo !== 2 * HT) begin fails++; $display("FAIL vs_low_cycles got %0d exp %0d", vs_lo, 2 * HT); end
    tests++; if (vo_hi !== 32) begin fails++; $display("FAIL video_on_cycles got %0d exp 32", vo_hi); end
    tests++; if (ls_n !== VT || fs_n !== 1) begin fails++; $display("FAIL strobe_counts got ls=%0d fs=%0d exp %0d 1", ls_n, fs_n, VT); end
  endtask

  task automatic test_out_delay();
    int fall0 = -1, fall1 = -1;
    logic p0 = 1'b1, p1 = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < FT + 20; k++) begin
      tick();
      tests++; if (o1 !== model(n, 3, 0, 0)) begin fails++; $display("FAIL delay n=%0d got %h exp %h", n, o1, model(n, 3, 0, 0)); end
      if (fall0 < 0 && p0 && !hs0) fall0 = n;
      if (fall1 < 0 && p1 && !hs1) fall1 = n;
      p0 = hs0; p1 = hs1;
    end
    tests++; if (fall0 < 0 || fall1 - fall0 !== 3) begin fails++; $display("FAIL hs_edge_shift got %0d exp 3", fall1 - fall0); end
  endtask

  task automatic test_polarity();
    int hs_hi = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < FT + 10; k++) begin
      tick();
      tests++; if (o2 !== model(n, 0, 1, 1)) begin fails++; $display("FAIL pol n=%0d got %h exp %h", n, o2, model(n, 0, 1, 1)); end
      if (n >= 1 && n <= FT) hs_hi += hs2;
    end
    tests++; if (hs_hi !== 3 * VT) begin fails++; $display("FAIL pol_hs_high got %0d exp %0d", hs_hi, 3 * VT); end
  endtask

  // Reset while the counters sit at h=5, v=2.
  task automatic test_mid_reset();
    int guard = 0;
    while (n % FT != 2 * HT + 5 && guard < 4 * FT) begin tick(); guard++; end
    tests++; if (guard >= 4 * FT) begin fails++; $display("FAIL mid_reset_wait got timeout exp h5v2"); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (o0 !== model(0, 0, 0, 0)) begin fails++; $display("FAIL mid_reset_d0 got %h exp %h", o0, model(0, 0, 0, 0)); end
    tests++; if (o1 !== model(0, 3, 0, 0)) begin fails++; $display("FAIL mid_reset_d1 got %h exp %h", o1, model(0, 3, 0, 0)); end
    tick();
    tests++; if (fs0 !== 1'b1 || ha0 !== 12'd0 || pix0 !== 1'b1) begin fails++; $display("FAIL restart got fs=%b ha=%0d pix=%b exp 1 0 1", fs0, ha0, pix0); end
    tests++; if (o1 !== model(n, 3, 0, 0)) begin fails++; $display("FAIL restart_d1 got %h exp %h", o1, model(n, 3, 0, 0)); end
  endtask

  task automatic test_random_reset();
    int run;
    for (int it = 0; it < 12; it++) begin
      run = $urandom_range(1, 260);
      for (int k = 0; k < run; k++) begin
        tick();
        tests++; if ({o0, o1, o2} !== {model(n, 0, 0, 0), model(n, 3, 0, 0), model(n, 0, 1, 1)}) begin
          fails++; $display("FAIL rand n=%0d got %h %h %h exp %h %h %h", n, o0, o1, o2,
                            model(n, 0, 0, 0), model(n, 3, 0, 0), model(n, 0, 1, 1));
        end
      end
      rst = 1'b1;
      run = $urandom_range(1, 3);
      for (int k = 0; k < run; k++) tick();
      rst = 1'b0;
    end
  endtask

`ifdef VGA_TIMING_RUNTIME_EN
  task automatic test_runtime();
    int guard = 0, ls_n, pix_n, maxh;
    rst = 1'b1; tick(); rst = 1'b0;
    while (n < 50) tick();
    c_hva = 12'd4; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    while (!fs3 && guard < 300) begin tick(); guard++; end
    tests++; if (n !== FT + 1) begin fails++; $display("FAIL cfg_old_frame got fs at %0d exp %0d", n, FT + 1); end
    ls_n = ls3; pix_n = pix3; maxh = ha3;
    for (int k = 1; k < 80; k++) begin
      tick();
      ls_n += ls3; pix_n += pix3;
      if (ha3 > maxh) maxh = ha3;
    end
    tick();
    tests++; if (fs3 !== 1'b1) begin fails++; $display("FAIL cfg_new_frame got fs=%b exp 1", fs3); end
    tests++; if (ls_n !== 8 || pix_n !== 16) begin fails++; $display("FAIL cfg_new_lines got ls=%0d pix=%0d exp 8 16", ls_n, pix_n); end
    tests++; if (maxh !== 3) begin fails++; $display("FAIL cfg_hmax got %0d exp 3", maxh); end
  endtask
`endif

  initial begin
    test_reset();
    test_small_timing();
    test_out_delay();
    test_polarity();
    test_mid_reset();
    test_random_reset();
`ifdef VGA_TIMING_RUNTIME_EN
    test_runtime();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
